// File: rtl/wallace_mul_arbiter.sv
// Two-requester arbiter that time-shares one external combinational multiplier.
// Optional grant/stall counters are enabled with `define WALLACE_ARB_STATS_EN.
module wallace_mul_arbiter #(
   parameter int W      = 16,
   parameter int SETTLE = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   output logic [W-1:0]   mul_a,
   output logic [W-1:0]   mul_b,
   input  logic [2*W-1:0] mul_p,
   output logic           rsp_valid,
   output logic           rsp_id,
   output logic [2*W-1:0] rsp_p,
   input  logic           rsp_ready,
`ifdef WALLACE_ARB_STATS_EN
   output logic [15:0]    gnt0_cnt,
   output logic [15:0]    gnt1_cnt,
   output logic [15:0]    stall_cnt,
`endif
   output logic           busy
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cnt;
   logic       r_last_grant;
   logic       w_grant_ok;
   logic       w_grant;
   logic       w_pick1;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_ok  = (r_state == S_IDLE) || ((r_state == S_DONE) && rsp_ready);
      w_pick1     = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
      w_grant     = w_grant_ok && (req0_valid || req1_valid);
      req0_ready  = w_grant && !w_pick1;
      req1_ready  = w_grant && w_pick1;
      busy        = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: if (w_grant) w_state_nxt = S_MUL;
         S_MUL:  if (r_cnt == 4'd0) w_state_nxt = S_DONE;
         S_DONE: if (rsp_ready) w_state_nxt = w_grant ? S_MUL : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_last_grant <= 1'b1;
         mul_a        <= '0;
         mul_b        <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_p        <= '0;
      end else begin
         r_state <= w_state_nxt;
         // A grant in DONE only happens on the accepting edge, so rsp_id may be reloaded here.
         if (w_grant) begin
            mul_a        <= w_pick1 ? req1_a : req0_a;
            mul_b        <= w_pick1 ? req1_b : req0_b;
            rsp_id       <= w_pick1;
            r_last_grant <= w_pick1;
            r_cnt        <= CNT_LOAD;
         end
         if (r_state == S_MUL) begin
            if (r_cnt == 4'd0) begin
               rsp_p     <= mul_p;
               rsp_valid <= 1'b1;
            end else begin
               r_cnt <= r_cnt - 4'd1;
            end
         end
         if ((r_state == S_DONE) && rsp_ready) rsp_valid <= 1'b0;
      end
   end

`ifdef WALLACE_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt0_cnt  <= '0;
         gnt1_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (req0_ready) gnt0_cnt <= gnt0_cnt + 16'd1;
         if (req1_ready) gnt1_cnt <= gnt1_cnt + 16'd1;
         if ((r_state == S_DONE) && !rsp_ready && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Directed bench for wallace_mul_arbiter: scoreboard of expected products keyed by handshake.
// Stats counters are checked when WALLACE_ARB_STATS_EN is defined.
module tb_wallace_mul_arbiter;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
   logic [W-1:0]   mul_a, mul_b;
   logic [2*W-1:0] mul_p;
   logic           rsp_valid, rsp_id, rsp_ready, busy;
   logic [2*W-1:0] rsp_p;
`ifdef WALLACE_ARB_STATS_EN
   logic [15:0]    gnt0_cnt, gnt1_cnt, stall_cnt;
`endif

   always #5 clk = ~clk;

   // Stand-in for the external Wallace-tree multiplier.
   assign mul_p = 32'(mul_a) * 32'(mul_b);

   wallace_mul_arbiter #(.W(W), .SETTLE(2)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_ready(rsp_ready),
`ifdef WALLACE_ARB_STATS_EN
      .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt), .stall_cnt(stall_cnt),
`endif
      .busy(busy)
   );

   typedef struct packed {
      logic        id;
      logic [31:0] p;
   } exp_t;

   exp_t        sb[$];
   int          g_order[$];
   int          n_cmp = 0, n_fail = 0;
   int          n_rdy0 = 0, n_rdy1 = 0, n_acc = 0, n_rv = 0, n_bb = 0, n_stall = 0;
   logic        s_rdy0, s_rdy1, s_rv, s_acc;
   logic [31:0] last_p;
   logic        last_id;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Observe one cycle: push on handshakes, pop and compare on accepted responses.
   task automatic sample();
      exp_t e;
      s_rdy0 = req0_ready;
      s_rdy1 = req1_ready;
      s_rv   = rsp_valid;
      s_acc  = rsp_valid && rsp_ready;
      check("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
      if (s_rv) n_rv++;
      if (s_rv && !rsp_ready) n_stall++;
      if (s_rdy0) begin
         n_rdy0++;
         g_order.push_back(0);
         sb.push_back('{1'b0, 32'(req0_a) * 32'(req0_b)});
      end
      if (s_rdy1) begin
         n_rdy1++;
         g_order.push_back(1);
         sb.push_back('{1'b1, 32'(req1_a) * 32'(req1_b)});
      end
      if (s_acc) begin
         n_acc++;
         if (s_rdy0 || s_rdy1) n_bb++;
         if (sb.size() == 0) begin
            check("rsp_unexpected", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_p", rsp_p, e.p);
            last_p  = rsp_p;
            last_id = rsp_id;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy(input int which, input string tag);
      int k = 0;
      do begin
         tick();
         k++;
      end while (!(which == 1 ? s_rdy1 : s_rdy0) && k < 20);
      check(tag, 32'(which == 1 ? s_rdy1 : s_rdy0), 32'd1);
   endtask

   task automatic wait_rv(output int lat, input string tag);
      int k = 0;
      do begin
         tick();
         k++;
      end while (!s_rv && k < 20);
      lat = k;
      check(tag, 32'(s_rv), 32'd1);
   endtask

   initial begin
      int lat, acc0, bb0, rdy1_0, rv0;
      rst = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0;
      rsp_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_p", rsp_p, 32'd0);
      check("rst_mul_a", 32'(mul_a), 32'd0);
      check("rst_mul_b", 32'(mul_b), 32'd0);

      // Single request 25*25.
      req0_valid = 1'b1; req0_a = 16'd25; req0_b = 16'd25;
      wait_rdy(0, "t1_grant");
      req0_valid = 1'b0;
      check("t1_busy", 32'(busy), 32'd1);
      wait_rv(lat, "t1_rsp");
      check("t1_latency", 32'(lat), 32'd3);
      check("t1_p", last_p, 32'd625);
      check("t1_id", 32'(last_id), 32'd0);
      check("t1_ready_pulses", 32'(n_rdy0), 32'd1);
      check("t1_busy_done", 32'(busy), 32'd0);

      // Max operands on requester 1.
      req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'hFFFF;
      wait_rdy(1, "t2_grant");
      req1_valid = 1'b0;
      wait_rv(lat, "t2_rsp");
      check("t2_p", last_p, 32'hFFFE0001);
      check("t2_id", 32'(last_id), 32'd1);

      // Contention: both continuously valid, expect 0,1,0,1 with back-to-back grants.
      g_order.delete();
      acc0 = n_acc;
      bb0  = n_bb;
      req0_valid = 1'b1; req0_a = 16'd100; req0_b = 16'd2;
      req1_valid = 1'b1; req1_a = 16'd45;  req1_b = 16'd2;
      for (int k = 0; k < 60 && (n_acc - acc0) < 4; k++) begin
         tick();
         if (g_order.size() >= 4) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
      end
      check("t3_responses", 32'(n_acc - acc0), 32'd4);
      check("t3_grants", 32'(g_order.size()), 32'd4);
      for (int i = 0; i < 4 && i < g_order.size(); i++)
         check("t3_order", 32'(g_order[i]), 32'(i % 2));
      check("t3_back_to_back", 32'(n_bb - bb0), 32'd3);

      // Backpressure: result held for 5 stalled cycles, no grants, then immediate grant.
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd5;
      req1_valid = 1'b1; req1_a = 16'd4; req1_b = 16'd6;
      wait_rdy(0, "t4_grant0");
      req0_valid = 1'b0;
      wait_rv(lat, "t4_rsp");
      rdy1_0 = n_rdy1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_hold_valid", 32'(rsp_valid), 32'd1);
         check("t4_hold_p", rsp_p, 32'd15);
         check("t4_hold_id", 32'(rsp_id), 32'd0);
      end
      check("t4_no_grant", 32'(n_rdy1), 32'(rdy1_0));
      rsp_ready = 1'b1;
      tick();
      check("t4_accept", 32'(s_acc), 32'd1);
      check("t4_next_grant", 32'(s_rdy1), 32'd1);
      req1_valid = 1'b0;
      wait_rv(lat, "t4_rsp1");
      check("t4_p1", last_p, 32'd24);

`ifdef WALLACE_ARB_STATS_EN
      check("stats_gnt0", 32'(gnt0_cnt), 32'(n_rdy0));
      check("stats_gnt1", 32'(gnt1_cnt), 32'(n_rdy1));
      check("stats_stall", 32'(stall_cnt), 32'(n_stall));
`endif

      // Reset while 7*9 is in MUL: no response, priority back to requester 0.
      req0_valid = 1'b1; req0_a = 16'd7; req0_b = 16'd9;
      wait_rdy(0, "t5_grant");
      req0_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t5_rsp_p", rsp_p, 32'd0);
      check("t5_rsp_id", 32'(rsp_id), 32'd0);
      check("t5_mul_a", 32'(mul_a), 32'd0);
      check("t5_mul_b", 32'(mul_b), 32'd0);
`ifdef WALLACE_ARB_STATS_EN
      check("t5_stats_clr", 32'(gnt0_cnt), 32'd0);
`endif
      sb.delete();
      rst = 1'b0;
      rv0 = n_rv;
      repeat (6) tick();
      check("t5_no_rsp", 32'(n_rv), 32'(rv0));

      g_order.delete();
      acc0 = n_acc;
      req0_valid = 1'b1; req0_a = 16'd2; req0_b = 16'd3;
      req1_valid = 1'b1; req1_a = 16'd4; req1_b = 16'd5;
      for (int k = 0; k < 40 && (n_acc - acc0) < 2; k++) begin
         tick();
         if (s_rdy0) req0_valid = 1'b0;
         if (s_rdy1) req1_valid = 1'b0;
      end
      check("t5_responses", 32'(n_acc - acc0), 32'd2);
      if (g_order.size() > 0) check("t5_first_grant", 32'(g_order[0]), 32'd0);
      else check("t5_first_grant", 32'(g_order.size()), 32'd1);
      check("t5_sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
